// File: rtl/wb_deserializer_pkg.sv
// Register map, frame geometry, FSM encoding and status layout for wb_deserializer.
// Defining DESER_PARITY_EN adds a trailing even-parity bit and the PARITY state.
package WBDeserializer;

  localparam int SYM_BITS   = 9;
  localparam int FRAME_BITS = 3 * SYM_BITS;
  localparam int NUM_REGS   = 2;
  localparam int ADR_W      = $bits(NUM_REGS);

  localparam logic [ADR_W-1:0] ADR_DATA   = ADR_W'(0);
  localparam logic [ADR_W-1:0] ADR_STATUS = ADR_W'(1);

`ifdef DESER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  // Field order matches the STATUS register, bit 3 down to bit 0.
  typedef struct packed {
    logic framing_err;
    logic parity_err;
    logic overrun;
    logic valid;
  } status_t;

endpackage

// File: rtl/wb_deserializer_if.sv
// Wishbone classic slave bundle for wb_deserializer (combinational ACK/ERR).
interface wb_deserializer_if;

  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic        ACK_O;
  logic        ERR_O;
  logic [31:0] DAT_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  ACK_O, ERR_O, DAT_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output ACK_O, ERR_O, DAT_O
  );

endinterface

// File: rtl/wb_deserializer_core.sv
// Serial receive path: 2-flop synchronizer, bit-timing FSM and payload shift register.
// With DESER_PARITY_EN the frame carries one even-parity bit before the stop bit.
module deserializer_core #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FRAME_BITS   = WBDeserializer::FRAME_BITS
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  data_i,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  framing_set
`ifdef DESER_PARITY_EN
  ,
  output logic                  parity_set
`endif
);

  import WBDeserializer::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(FRAME_BITS);

  logic [1:0]            sync_q;
  logic                  line;
  logic                  line_q;
  logic                  rise;
  logic                  expire;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [BIT_W-1:0]      bits_left, bits_left_d;
  logic [FRAME_BITS-1:0] shreg, shreg_d;

  assign line   = sync_q[1];
  assign rise   = line & ~line_q;
  assign expire = (cnt == CNT_W'(1));
  assign frame  = shreg;

  // NOTE: state elements use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync_q    <= '0;
      line_q    <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      bits_left <= '0;
      // NOTE: the payload register is plain flops, so it is cleared with the control state and a reset mid-frame leaves nothing behind.
      shreg     <= '0;
    end else begin
      sync_q    <= {sync_q[0], data_i};
      line_q    <= line;
      state     <= state_d;
      cnt       <= cnt_d;
      bits_left <= bits_left_d;
      shreg     <= shreg_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    bits_left_d = bits_left;
    shreg_d     = shreg;
    done        = 1'b0;
    framing_set = 1'b0;
`ifdef DESER_PARITY_EN
    parity_set  = 1'b0;
`endif

    // Bit timer runs only while a bit period is being timed; expiry branches reload it.
    if (state != IDLE && state != DONE && !expire) cnt_d = cnt - CNT_W'(1);

    case (state)
      IDLE: begin
        if (rise) begin
          state_d = START;
          cnt_d   = HALF_BIT;
        end
      end
      START: begin
        if (expire) begin
          if (line) begin
            state_d     = DATA;
            cnt_d       = FULL_BIT;
            bits_left_d = ALL_BITS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shreg_d     = {shreg[FRAME_BITS-2:0], line};
          bits_left_d = bits_left - BIT_W'(1);
          cnt_d       = FULL_BIT;
          if (bits_left == BIT_W'(1)) begin
`ifdef DESER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        if (expire) begin
          parity_set = line ^ (^shreg);
          cnt_d      = FULL_BIT;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          framing_set = line;
          state_d     = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/wb_deserializer.sv
// Wishbone-mapped serial frame receiver: DATA (addr 0) and STATUS (addr 1) registers.
// Define DESER_PARITY_EN to enable the parity bit and the STATUS parity_err flag.
module wb_deserializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FRAME_BITS   = WBDeserializer::FRAME_BITS
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              data_i,
  wb_deserializer_if.slave  wb
);

  import WBDeserializer::*;

  logic                  core_done;
  logic                  core_framing;
  logic                  core_parity;
  logic [FRAME_BITS-1:0] core_frame;

  logic [FRAME_BITS-1:0] rx_data, rx_data_d;
  status_t               status, status_d;

  logic [ADR_W-1:0]      adr;
  logic                  access;
  logic                  rd_data;
  logic                  rd_status;
  logic                  wr_status;
  logic                  ack;
  logic                  unused_dat;

  deserializer_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FRAME_BITS   (FRAME_BITS)
  ) u_core (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .data_i       (data_i),
    .done         (core_done),
    .frame        (core_frame),
    .framing_set  (core_framing)
`ifdef DESER_PARITY_EN
    ,
    .parity_set   (core_parity)
`endif
  );

`ifndef DESER_PARITY_EN
  assign core_parity = 1'b0;
`endif

  assign adr       = wb.ADR_I[ADR_W-1:0];
  assign access    = wb.CYC_I & wb.STB_I;
  assign rd_data   = access & ~wb.WE_I & (adr == ADR_DATA);
  assign rd_status = access & ~wb.WE_I & (adr == ADR_STATUS);
  assign wr_status = access &  wb.WE_I & (adr == ADR_STATUS);

  // Everything that is not a mapped read or a STATUS write is answered with ERR.
  assign ack       = rd_data | rd_status | wr_status;
  assign wb.ACK_O  = ack;
  assign wb.ERR_O  = access & ~ack;

  assign unused_dat = ^{wb.DAT_I[31:4], wb.DAT_I[0]};

  always_comb begin
    wb.DAT_O = '0;
    if (rd_data)        wb.DAT_O = 32'(rx_data);
    else if (rd_status) wb.DAT_O = 32'(status);
  end

  // Clears are applied before sets so a flag event in the same cycle always wins.
  always_comb begin
    status_d  = status;
    rx_data_d = rx_data;

    if (wr_status) begin
      if (wb.DAT_I[3]) status_d.framing_err = 1'b0;
      if (wb.DAT_I[2]) status_d.parity_err  = 1'b0;
      if (wb.DAT_I[1]) status_d.overrun     = 1'b0;
    end
    if (rd_data) status_d.valid = 1'b0;

    if (core_framing) status_d.framing_err = 1'b1;
    if (core_parity)  status_d.parity_err  = 1'b1;

    if (core_done) begin
      rx_data_d      = core_frame;
      status_d.valid = 1'b1;
      // A frame landing on unread data is an overrun, unless that data is being read right now.
      if (status.valid && !rd_data) status_d.overrun = 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_data <= '0;
      status  <= '0;
    end else begin
      rx_data <= rx_data_d;
      status  <= status_d;
    end
  end

endmodule

// File: tb/tb_wb_deserializer.sv
// Scoreboard bench for wb_deserializer: frames are modelled on send and checked on DATA reads.
// Define DESER_PARITY_EN for the parity build; the parity-error case is then included.
module tb_wb_deserializer;

  import WBDeserializer::*;

  localparam int C = 4;

  localparam logic [26:0] F_A = {9'h1BC, 9'h012, 9'h034};
  localparam logic [26:0] F_B = {9'h0AA, 9'h155, 9'h00F};
  localparam logic [26:0] F_C = {9'h101, 9'h0FE, 9'h180};
  localparam logic [26:0] F_D = {9'h07C, 9'h1C3, 9'h055};
  localparam logic [26:0] F_E = {9'h1FF, 9'h000, 9'h0A5};
  localparam logic [26:0] F_F = {9'h03C, 9'h13C, 9'h1E1};
  localparam logic [26:0] F_G = {9'h0C0, 9'h111, 9'h022};
  localparam logic [26:0] F_H = {9'h1A5, 9'h05A, 9'h133};
  localparam logic [26:0] F_I = {9'h1FF, 9'h1FF, 9'h1FF};
  localparam logic [26:0] F_J = {9'h012, 9'h134, 9'h056};
  localparam logic [26:0] F_K = {9'h0DE, 9'h1AD, 9'h0BE};

  logic CLK_I = 1'b0;
  logic RST_I;
  logic data_i;

  wb_deserializer_if wb();

  wb_deserializer #(
    .CLKS_PER_BIT (C),
    .FRAME_BITS   (27)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .data_i (data_i),
    .wb     (wb)
  );

  always #5 CLK_I = ~CLK_I;

  int n_vec = 0;
  int n_err = 0;

`ifdef DESER_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // Reference model: unread frames queue, last loaded frame and sticky flags.
  logic [26:0] sb_q[$];
  logic [26:0] m_last;
  logic        m_valid, m_ovr, m_frm, m_par;

  function automatic logic [31:0] m_status();
    return {28'b0, m_frm, m_par, m_ovr, m_valid};
  endfunction

  function automatic void model_reset();
    sb_q.delete();
    m_last  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_frm   = 1'b0;
    m_par   = 1'b0;
  endfunction

  function automatic void model_frame(input logic [26:0] p);
    if (m_valid) begin
      m_ovr = 1'b1;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    sb_q.push_back(p);
    m_valid = 1'b1;
  endfunction

  function automatic logic [26:0] model_read();
    if (sb_q.size() > 0) m_last = sb_q.pop_front();
    m_valid = 1'b0;
    return m_last;
  endfunction

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic settle();
    repeat (C + 8) tick();
  endtask

  // One bus cycle; returns {ACK_O, ERR_O, DAT_O} sampled mid-cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [33:0] rsp);
    wb.CYC_I = 1'b1;
    wb.STB_I = 1'b1;
    wb.WE_I  = we;
    wb.ADR_I = adr;
    wb.DAT_I = wdat;
    #2;
    rsp = {wb.ACK_O, wb.ERR_O, wb.DAT_O};
    tick();
    wb.CYC_I = 1'b0;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
  endtask

  task automatic rd_status(input string tag);
    logic [33:0] r;
    wb_xfer(1'b0, 32'(ADR_STATUS), 32'h0, r);
    check(tag, r, {2'b10, m_status()});
  endtask

  task automatic rd_data(input string tag);
    logic [33:0] r;
    logic [26:0] exp;
    wb_xfer(1'b0, 32'(ADR_DATA), 32'h0, r);
    exp = model_read();
    check(tag, r, {2'b10, 32'(exp)});
  endtask

  task automatic wr_status(input string tag, input logic [31:0] v);
    logic [33:0] r;
    wb_xfer(1'b1, 32'(ADR_STATUS), v, r);
    check(tag, r, {2'b10, 32'h0});
    if (v[3]) m_frm = 1'b0;
    if (v[2]) m_par = 1'b0;
    if (v[1]) m_ovr = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    data_i = b;
    repeat (C) tick();
  endtask

  task automatic send_frame(input logic [26:0] p, input logic stop_v);
    drive_bit(1'b1);
    for (int i = 26; i >= 0; i--) drive_bit(p[i]);
`ifdef DESER_PARITY_EN
    drive_bit((^p) ^ par_flip);
`endif
    drive_bit(stop_v);
    data_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [33:0] r;
    logic        found;
    int          k;

    wb.CYC_I = 1'b0;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    wb.ADR_I = '0;
    wb.DAT_I = '0;
    data_i   = 1'b0;
    RST_I    = 1'b1;
    model_reset();
    repeat (3) tick();

    // Register reads are still answered while reset is held.
    rd_status("rst_status");
    RST_I = 1'b0;
    tick();
    #2;
    check("idle_bus", {wb.ACK_O, wb.ERR_O, wb.DAT_O}, 34'h0);
    rd_data("rst_data");

    // Basic frame, read, valid clears.
    send_frame(F_A, 1'b0);
    settle();
    model_frame(F_A);
    rd_status("a_status");
    rd_data("a_data");
    rd_status("a_cleared");

    // Overrun, then write-1-to-clear of overrun only.
    send_frame(F_B, 1'b0);
    settle();
    model_frame(F_B);
    send_frame(F_C, 1'b0);
    settle();
    model_frame(F_C);
    rd_status("ovr_status");
    wr_status("ovr_w1c", 32'h2);
    rd_status("ovr_after_w1c");
    rd_data("ovr_data");
    rd_status("ovr_cleared");

    // One-cycle glitch is rejected; the receiver still takes the next frame.
    data_i = 1'b1;
    tick();
    data_i = 1'b0;
    settle();
    rd_status("glitch_status");
    send_frame(F_D, 1'b0);
    settle();
    model_frame(F_D);
    rd_data("glitch_next_data");

    // Find the cycle in which a frame loads, measured from the start-bit drive.
    found = 1'b0;
    k     = 120;
    fork
      send_frame(F_E, 1'b0);
      begin : poll
        logic [33:0] pr;
        for (int i = 0; i < 400; i++) begin
          wb_xfer(1'b0, 32'(ADR_STATUS), 32'h0, pr);
          if (pr[0]) begin
            found = 1'b1;
            k     = i;
            break;
          end
        end
      end
    join
    check("load_seen", 34'(found), 34'h1);
    model_frame(F_E);
    settle();

    // DATA read in the same cycle the next frame loads: the new frame wins, no overrun.
    fork
      send_frame(F_F, 1'b0);
      begin
        repeat (k - 1) tick();
        wb_xfer(1'b0, 32'(ADR_DATA), 32'h0, r);
      end
    join
    check("coll_data", r, {2'b10, 32'(model_read())});
    model_frame(F_F);
    settle();
    rd_status("coll_status");
    rd_data("coll_new_data");

    // Bad stop bit, with a framing clear landing in the very cycle the flag is set.
    fork
      send_frame(F_G, 1'b1);
      begin
        repeat (k - 2) tick();
        wb_xfer(1'b1, 32'(ADR_STATUS), 32'h8, r);
      end
    join
    check("setwins_ack", r, {2'b10, 32'h0});
    m_frm = 1'b1;
    model_frame(F_G);
    settle();
    rd_status("framing_status");
    wr_status("framing_w1c", 32'h8);
    rd_status("framing_cleared");
    rd_data("framing_data");

`ifdef DESER_PARITY_EN
    // Wrong parity bit: flag set, frame still loads.
    par_flip = 1'b1;
    send_frame(F_H, 1'b0);
    par_flip = 1'b0;
    settle();
    m_par = 1'b1;
    model_frame(F_H);
    rd_status("parity_status");
    wr_status("parity_w1c", 32'h4);
    rd_data("parity_data");
    rd_status("parity_cleared");
`endif

    // Reset in the middle of the payload discards the partial frame.
    drive_bit(1'b1);
    for (int i = 26; i >= 17; i--) drive_bit(F_I[i]);
    data_i = 1'b0;
    RST_I  = 1'b1;
    model_reset();
    repeat (3) tick();
    rd_status("midrst_status");
    RST_I = 1'b0;
    tick();
    send_frame(F_J, 1'b0);
    settle();
    model_frame(F_J);
    rd_status("midrst_clean_status");
    rd_data("midrst_clean_data");

    // Unmapped read and DATA write error out and leave the registers untouched.
    send_frame(F_K, 1'b0);
    settle();
    model_frame(F_K);
    wb_xfer(1'b0, 32'h2, 32'h0, r);
    check("err_rd_adr2", r, {2'b01, 32'h0});
    wb_xfer(1'b1, 32'(ADR_DATA), 32'hFFFF_FFFF, r);
    check("err_wr_data", r, {2'b01, 32'h0});
    wr_status("w1c_bit0", 32'h1);
    rd_status("err_status");
    rd_data("err_data");
    rd_status("err_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
